bcd_convert_scheduler: RTL



---
 rtl/bcd_convert_scheduler_pkg.sv | 27 ++
 rtl/bcd_convert_scheduler_if.sv | 32 +++
 rtl/bcd8421_to_2421.sv | 32 +++
 rtl/bcd_convert_scheduler.sv | 130 +++++++++++++
 4 files changed

// File: rtl/bcd_convert_scheduler_pkg.sv
// Shared definitions for the two-requester BCD 8421-to-2421 conversion scheduler:
// FSM encoding, 2421 code constants and counter sizing.
package bcd_convert_scheduler_pkg;

  localparam int CNT_W = 8;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CONV = 2'b01,
    ST_HOLD = 2'b10
  } state_e;

  // 2421 codes for decimal digits 0-9 (upper half uses the complementary form)
  localparam logic [3:0] C2421_0 = 4'b0000;
  localparam logic [3:0] C2421_1 = 4'b0001;
  localparam logic [3:0] C2421_2 = 4'b0010;
  localparam logic [3:0] C2421_3 = 4'b0011;
  localparam logic [3:0] C2421_4 = 4'b0100;
  localparam logic [3:0] C2421_5 = 4'b1011;
  localparam logic [3:0] C2421_6 = 4'b1100;
  localparam logic [3:0] C2421_7 = 4'b1101;
  localparam logic [3:0] C2421_8 = 4'b1110;
  localparam logic [3:0] C2421_9 = 4'b1111;

endpackage

// File: rtl/bcd_convert_scheduler_if.sv
// Requester, result and status signals of the BCD conversion scheduler.
interface bcd_convert_scheduler_if;
  import bcd_convert_scheduler_pkg::*;

  logic             req0_valid;
  logic [3:0]       req0_data;
  logic             req0_ready;
  logic             req1_valid;
  logic [3:0]       req1_data;
  logic             req1_ready;
  logic             out_valid;
  logic [3:0]       out_data;
  logic             out_src;
  logic             out_err;
  logic             out_ready;
  logic             busy;
  logic [CNT_W-1:0] conv_count;
  logic [CNT_W-1:0] err_count;

  modport master (
    output req0_valid, req0_data, req1_valid, req1_data, out_ready,
    input  req0_ready, req1_ready, out_valid, out_data, out_src, out_err,
           busy, conv_count, err_count
  );

  modport slave (
    input  req0_valid, req0_data, req1_valid, req1_data, out_ready,
    output req0_ready, req1_ready, out_valid, out_data, out_src, out_err,
           busy, conv_count, err_count
  );

endinterface

// File: rtl/bcd8421_to_2421.sv
// Purely combinational 8421 to 2421 digit converter; non-BCD inputs yield ERR_CODE
// with err raised.
module bcd8421_to_2421
  import bcd_convert_scheduler_pkg::*;
#(
  parameter logic [3:0] ERR_CODE = 4'b0000
) (
  input  logic [3:0] digit,
  output logic [3:0] code,
  output logic       err
);

  // Digit lookup; 10-15 fall through to the error code
  always_comb begin
    code = ERR_CODE;
    err  = 1'b1;
    case (digit)
      4'd0: begin code = C2421_0; err = 1'b0; end
      4'd1: begin code = C2421_1; err = 1'b0; end
      4'd2: begin code = C2421_2; err = 1'b0; end
      4'd3: begin code = C2421_3; err = 1'b0; end
      4'd4: begin code = C2421_4; err = 1'b0; end
      4'd5: begin code = C2421_5; err = 1'b0; end
      4'd6: begin code = C2421_6; err = 1'b0; end
      4'd7: begin code = C2421_7; err = 1'b0; end
      4'd8: begin code = C2421_8; err = 1'b0; end
      4'd9: begin code = C2421_9; err = 1'b0; end
      default: begin code = ERR_CODE; err = 1'b1; end
    endcase
  end

endmodule

// File: rtl/bcd_convert_scheduler.sv
// Round-robin scheduler feeding one 8421-to-2421 converter from two requesters,
// holding each registered result until the consumer takes it.
module bcd_convert_scheduler
  import bcd_convert_scheduler_pkg::*;
#(
  parameter logic [3:0] ERR_CODE = 4'b0000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  bcd_convert_scheduler_if.slave bus
);

  state_e           state_r;
  state_e           state_s;
  logic             prio_r;
  logic [3:0]       digit_r;
  logic             src_r;
  logic             out_valid_r;
  logic [3:0]       out_data_r;
  logic             out_src_r;
  logic             out_err_r;
  logic [CNT_W-1:0] conv_count_r;
  logic [CNT_W-1:0] err_count_r;
  logic             grant_valid_s;
  logic             grant_src_s;
  logic [3:0]       code_s;
  logic             code_err_s;

  bcd8421_to_2421 #(.ERR_CODE(ERR_CODE)) u_conv (
    .digit (digit_r),
    .code  (code_s),
    .err   (code_err_s)
  );

  // Arbitration: prio_r names the requester that wins a tie
  always_comb begin
    grant_valid_s = 1'b0;
    grant_src_s   = 1'b0;
    if (bus.req0_valid && bus.req1_valid) begin
      grant_valid_s = 1'b1;
      grant_src_s   = prio_r;
    end else if (bus.req0_valid) begin
      grant_valid_s = 1'b1;
      grant_src_s   = 1'b0;
    end else if (bus.req1_valid) begin
      grant_valid_s = 1'b1;
      grant_src_s   = 1'b1;
    end else begin
      grant_valid_s = 1'b0;
      grant_src_s   = 1'b0;
    end
  end

  // Ready is gated by rst_n so both stay low while reset is held
  assign bus.req0_ready = rst_n && (state_r == ST_IDLE) && grant_valid_s && !grant_src_s;
  assign bus.req1_ready = rst_n && (state_r == ST_IDLE) && grant_valid_s &&  grant_src_s;

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (grant_valid_s) state_s = ST_CONV;
        else               state_s = ST_IDLE;
      end
      ST_CONV: state_s = ST_HOLD;
      ST_HOLD: begin
        if (bus.out_ready) state_s = ST_IDLE;
        else               state_s = ST_HOLD;
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= ST_IDLE;
    else        state_r <= state_s;
  end

  // Capture, result register and delivery counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio_r       <= 1'b0;
      digit_r      <= 4'b0000;
      src_r        <= 1'b0;
      out_valid_r  <= 1'b0;
      out_data_r   <= 4'b0000;
      out_src_r    <= 1'b0;
      out_err_r    <= 1'b0;
      conv_count_r <= '0;
      err_count_r  <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (grant_valid_s) begin
            digit_r <= grant_src_s ? bus.req1_data : bus.req0_data;
            src_r   <= grant_src_s;
            prio_r  <= !grant_src_s;
          end
        end
        ST_CONV: begin
          out_data_r  <= code_s;
          out_err_r   <= code_err_s;
          out_src_r   <= src_r;
          out_valid_r <= 1'b1;
        end
        ST_HOLD: begin
          if (bus.out_ready) begin
            out_valid_r  <= 1'b0;
            conv_count_r <= conv_count_r + CNT_ONE;
            if (out_err_r && (err_count_r != CNT_MAX)) begin
              err_count_r <= err_count_r + CNT_ONE;
            end
          end
        end
        default: out_valid_r <= 1'b0;
      endcase
    end
  end

  assign bus.out_valid  = out_valid_r;
  assign bus.out_data   = out_data_r;
  assign bus.out_src    = out_src_r;
  assign bus.out_err    = out_err_r;
  assign bus.busy       = (state_r != ST_IDLE);
  assign bus.conv_count = conv_count_r;
  assign bus.err_count  = err_count_r;

endmodule
